// File: rtl/operand_fetch_stage.sv
// Decode-side operand stage: drives regfile read ports, resolves RAW hazards by
// bypass or stall, and holds the result in a single-entry valid/ready ID/EX register.
module operand_fetch_stage #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned CTRL_WIDTH = 8,
   parameter int unsigned ZERO_REG   = 31
) (
   input  logic                  clock,
   input  logic                  reset_n,

   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rn,
   input  logic [ADDR_WIDTH-1:0] in_rm,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_reg_write,
   input  logic                  in_mem_read,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,

   output logic [ADDR_WIDTH-1:0] rf_read_register1,
   output logic [ADDR_WIDTH-1:0] rf_read_register2,
   input  logic [DATA_WIDTH-1:0] rf_read_data1,
   input  logic [DATA_WIDTH-1:0] rf_read_data2,

   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic                  mem_reg_write,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_result,
   input  logic                  wb_reg_write,
   input  logic [ADDR_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,

   input  logic                  flush,

   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_op1,
   output logic [DATA_WIDTH-1:0] out_op2,
   output logic [ADDR_WIDTH-1:0] out_rd,
   output logic [DATA_WIDTH-1:0] out_imm,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic [31:0]           stall_count
);

   localparam int unsigned STALL_WIDTH = 32;
   localparam int unsigned NUM_SRC     = 2;

   logic                  out_valid_q,     out_valid_d;
   logic [DATA_WIDTH-1:0] out_op1_q,       out_op1_d;
   logic [DATA_WIDTH-1:0] out_op2_q,       out_op2_d;
   logic [ADDR_WIDTH-1:0] out_rd_q,        out_rd_d;
   logic [DATA_WIDTH-1:0] out_imm_q,       out_imm_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q,      out_ctrl_d;
   logic                  out_reg_write_q, out_reg_write_d;
   logic                  out_mem_read_q,  out_mem_read_d;
   logic [STALL_WIDTH-1:0] stall_count_q,  stall_count_d;

   logic [ADDR_WIDTH-1:0] src     [NUM_SRC];
   logic [DATA_WIDTH-1:0] rf_data [NUM_SRC];
   logic [DATA_WIDTH-1:0] op_sel  [NUM_SRC];
   logic [NUM_SRC-1:0]    src_hazard;
   logic                  hazard;
   logic                  free;
   logic                  accept;

   assign rf_read_register1 = in_rn;
   assign rf_read_register2 = in_rm;

   assign src[0]     = in_rn;
   assign src[1]     = in_rm;
   assign rf_data[0] = rf_read_data1;
   assign rf_data[1] = rf_read_data2;

   // Per-source bypass priority EX > MEM > WB > regfile; a loaded value in EX is not yet available.
   always_comb begin : operand_select
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         op_sel[i]     = rf_data[i];
         src_hazard[i] = 1'b0;
         if (src[i] == ADDR_WIDTH'(ZERO_REG)) begin
            op_sel[i] = '0;
         end else begin
            if (ex_reg_write && !ex_mem_read && (ex_rd == src[i])) begin
               op_sel[i] = ex_result;
            end else if (mem_reg_write && (mem_rd == src[i])) begin
               op_sel[i] = mem_result;
            end else if (wb_reg_write && (wb_rd == src[i])) begin
               op_sel[i] = wb_data;
            end
            src_hazard[i] = (out_valid_q && out_reg_write_q && (out_rd_q == src[i])) ||
                            (ex_reg_write && ex_mem_read && (ex_rd == src[i]));
         end
      end
   end

   assign hazard   = in_valid && (|src_hazard);
   assign free     = !out_valid_q || out_ready;
   assign in_ready = flush || (free && !hazard && reset_n);
   assign accept   = in_valid && in_ready && !flush;

   // Next-state for the ID/EX entry and the perf counter; flush outranks accept.
   always_comb begin : next_state
      out_valid_d     = out_valid_q;
      out_op1_d       = out_op1_q;
      out_op2_d       = out_op2_q;
      out_rd_d        = out_rd_q;
      out_imm_d       = out_imm_q;
      out_ctrl_d      = out_ctrl_q;
      out_reg_write_d = out_reg_write_q;
      out_mem_read_d  = out_mem_read_q;
      stall_count_d   = stall_count_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d     = 1'b1;
         out_op1_d       = op_sel[0];
         out_op2_d       = op_sel[1];
         out_rd_d        = in_rd;
         out_imm_d       = in_imm;
         out_ctrl_d      = in_ctrl;
         out_reg_write_d = in_reg_write;
         out_mem_read_d  = in_mem_read;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (hazard && !flush && (stall_count_q != {STALL_WIDTH{1'b1}})) begin
         stall_count_d = stall_count_q + STALL_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin : state_reg
      if (!reset_n) begin
         out_valid_q     <= 1'b0;
         out_op1_q       <= '0;
         out_op2_q       <= '0;
         out_rd_q        <= '0;
         out_imm_q       <= '0;
         out_ctrl_q      <= '0;
         out_reg_write_q <= 1'b0;
         out_mem_read_q  <= 1'b0;
         stall_count_q   <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_op1_q       <= out_op1_d;
         out_op2_q       <= out_op2_d;
         out_rd_q        <= out_rd_d;
         out_imm_q       <= out_imm_d;
         out_ctrl_q      <= out_ctrl_d;
         out_reg_write_q <= out_reg_write_d;
         out_mem_read_q  <= out_mem_read_d;
         stall_count_q   <= stall_count_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_op1       = out_op1_q;
   assign out_op2       = out_op2_q;
   assign out_rd        = out_rd_q;
   assign out_imm       = out_imm_q;
   assign out_ctrl      = out_ctrl_q;
   assign out_reg_write = out_reg_write_q;
   assign out_mem_read  = out_mem_read_q;
   assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed instructions push expected
// ID/EX entries; a monitor pops and compares on every out_valid/out_ready handshake.
module tb_operand_fetch_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rn, in_rm, in_rd;
   logic        in_reg_write, in_mem_read;
   logic [63:0] in_imm;
   logic [7:0]  in_ctrl;
   logic [4:0]  rf_read_register1, rf_read_register2;
   logic [63:0] rf_read_data1, rf_read_data2;
   logic        ex_reg_write, ex_mem_read;
   logic [4:0]  ex_rd;
   logic [63:0] ex_result;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [63:0] mem_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_op1, out_op2, out_imm;
   logic [4:0]  out_rd;
   logic [7:0]  out_ctrl;
   logic        out_reg_write, out_mem_read;
   logic [31:0] stall_count;

   typedef struct packed {
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic [7:0]  ctrl;
      logic        rw;
      logic        mr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   exp_t        mon_e;
   logic [63:0] rf [32];
   int          checks    = 0;
   int          failures  = 0;
   int          exp_stall = 0;

   always #5 clock = ~clock;

   assign rf_read_data1 = rf[rf_read_register1];
   assign rf_read_data2 = rf[rf_read_register2];

   operand_fetch_stage dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_imm(in_imm), .in_ctrl(in_ctrl),
      .rf_read_register1(rf_read_register1), .rf_read_register2(rf_read_register2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .ex_result(ex_result),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_imm(out_imm), .out_ctrl(out_ctrl),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .stall_count(stall_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
      end
   endtask

   // Present one instruction and record what the ID/EX entry should hold if accepted.
   task automatic instr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic rw, input logic [63:0] imm, input logic [7:0] ctrl,
                        input logic [63:0] e1, input logic [63:0] e2);
      in_valid     = 1'b1;
      in_rn        = rn;
      in_rm        = rm;
      in_rd        = rd;
      in_reg_write = rw;
      in_mem_read  = 1'b0;
      in_imm       = imm;
      in_ctrl      = ctrl;
      cur          = '{op1: e1, op2: e2, rd: rd, imm: imm, ctrl: ctrl, rw: rw, mr: 1'b0};
   endtask

   // One clock: check in_ready, push on accept, advance to just after the next falling edge.
   task automatic step(input logic exp_rdy);
      #1;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (in_valid && in_ready && !flush) exp_q.push_back(cur);
      @(negedge clock);
      #1;
   endtask

   always @(negedge clock) begin
      #3;
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=op1 0x%0h expected=no entry", out_op1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_op1",       out_op1,              mon_e.op1);
            chk("out_op2",       out_op2,              mon_e.op2);
            chk("out_rd",        64'(out_rd),          64'(mon_e.rd));
            chk("out_imm",       out_imm,              mon_e.imm);
            chk("out_ctrl",      64'(out_ctrl),        64'(mon_e.ctrl));
            chk("out_reg_write", 64'(out_reg_write),   64'(mon_e.rw));
            chk("out_mem_read",  64'(out_mem_read),    64'(mon_e.mr));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
      rf[1]  = 64'd5;
      rf[2]  = 64'd7;
      rf[31] = 64'hDEAD;
      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; ex_result = '0;
      mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'h0, 8'h0, 64'd5, 64'd7);

      // Reset with a valid instruction waiting
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      chk("reset_in_ready",  64'(in_ready),   64'd0);
      chk("reset_out_valid", 64'(out_valid),  64'd0);
      chk("reset_op1",       out_op1,         64'd0);
      chk("reset_op2",       out_op2,         64'd0);
      chk("reset_stall",     64'(stall_count), 64'd0);

      // Plain regfile read
      reset_n = 1'b1; out_ready = 1'b1;
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'hA, 8'h5A, 64'd5, 64'd7);
      step(1'b1);
      chk("accept_out_valid", 64'(out_valid), 64'd1);

      // Bypass priority EX > MEM > WB
      ex_reg_write = 1'b1;  ex_rd  = 5'd1; ex_result  = 64'h11;
      mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 64'h22;
      wb_reg_write = 1'b1;  wb_rd  = 5'd1; wb_data    = 64'h33;
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'hB, 8'h01, 64'h11, 64'd7);
      step(1'b1);
      ex_reg_write = 1'b0;
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'hC, 8'h02, 64'h22, 64'd7);
      step(1'b1);
      mem_reg_write = 1'b0;
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'hD, 8'h03, 64'h33, 64'd7);
      step(1'b1);
      wb_reg_write = 1'b0;

      // Load-use: one stall cycle, bubble, then MEM forward
      ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; ex_result = 64'hBAD;
      instr(5'd4, 5'd2, 5'd3, 1'b0, 64'hE, 8'h04, 64'h99, 64'd7);
      step(1'b0);
      exp_stall = 1;
      chk("loaduse_bubble", 64'(out_valid),   64'd0);
      chk("loaduse_stall",  64'(stall_count), 64'(exp_stall));
      ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 64'h99;
      step(1'b1);
      mem_reg_write = 1'b0;

      // XZR: never forwarded, never a hazard
      ex_reg_write = 1'b1; ex_rd = 5'd31; ex_result = 64'hFF;
      instr(5'd31, 5'd2, 5'd3, 1'b0, 64'hF, 8'h05, 64'd0, 64'd7);
      step(1'b1);
      chk("xzr_no_stall", 64'(stall_count), 64'(exp_stall));
      ex_reg_write = 1'b0;

      // Held producer rd=5 stalls a consumer of X5 until it drains
      instr(5'd1, 5'd2, 5'd5, 1'b1, 64'h10, 8'h06, 64'd5, 64'd7);
      step(1'b1);
      out_ready = 1'b0;
      instr(5'd1, 5'd5, 5'd3, 1'b0, 64'h11, 8'h07, 64'd5, 64'h1005);
      step(1'b0);
      step(1'b0);
      chk("held_rd", 64'(out_rd), 64'd5);
      out_ready = 1'b1;
      step(1'b0);
      exp_stall = 4;
      chk("held_stall", 64'(stall_count), 64'(exp_stall));
      step(1'b1);

      // Backpressure for 3 cycles with a dependent instruction, then flush
      instr(5'd2, 5'd1, 5'd6, 1'b1, 64'h12, 8'h08, 64'd7, 64'd5);
      step(1'b1);
      out_ready = 1'b0;
      instr(5'd6, 5'd2, 5'd3, 1'b0, 64'h13, 8'h09, 64'd0, 64'd7);
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_op1",   out_op1,        64'd7);
         chk("hold_imm",   out_imm,        64'h12);
      end
      exp_stall = 7;
      chk("hold_stall", 64'(stall_count), 64'(exp_stall));
      flush = 1'b1;
      exp_q.delete();
      step(1'b1);
      chk("flush_valid", 64'(out_valid),   64'd0);
      chk("flush_stall", 64'(stall_count), 64'(exp_stall));
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(1'b1);
      chk("flush_dropped", 64'(out_valid), 64'd0);

      // Reset during backpressure clears everything
      instr(5'd1, 5'd2, 5'd3, 1'b0, 64'h14, 8'h0A, 64'd5, 64'd7);
      step(1'b1);
      out_ready = 1'b0; in_valid = 1'b0;
      step(1'b0);
      reset_n = 1'b0;
      exp_q.delete();
      step(1'b0);
      chk("rst2_valid", 64'(out_valid),   64'd0);
      chk("rst2_op1",   out_op1,          64'd0);
      chk("rst2_stall", 64'(stall_count), 64'd0);
      reset_n = 1'b1; out_ready = 1'b1;
      step(1'b1);
      step(1'b1);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
